mux_n_1_scan_v: RTL and testbench
=================================

// Module: mux_n_1_scan_v
// PURPOSE
//  Parametrised N:1, W-bit registered multiplexer with valid/ready output handshake.
//  Two modes: direct (caller-driven select) and scan (internal counter walks channels 0..N-1).
//  Successor to the fixed 8:1 single-bit enable mux; used in datapaths to serialise N parallel words.
// PARAMETERS
//  W      8               data width per channel
//  N      8               channel count, N >= 2, need not be a power of 2
//  SEL_W  clog2(N)        select/channel-index width, derived, do not override
// PORTS
//  i_clk      in   1        single clock; all logic on rising edge
//  i_rst_n    in   1        reset, synchronous, active-low
//  i_en       in   1        global enable; 0 = no new capture, state held
//  i_mode     in   1        0 = direct, 1 = scan; sampled only in IDLE
//  i_start    in   1        scan start pulse; honoured only in IDLE with i_mode=1
//  i_sel      in   SEL_W    direct-mode channel select
//  i_data     in   N*W      channel k occupies bits [k*W +: W]
//  i_ready    in   1        downstream accepts o_data
//  o_data     out  W        registered selected word
//  o_ch       out  SEL_W    channel index of o_data
//  o_valid    out  1        o_data/o_ch valid
//  o_busy     out  1        1 while state != IDLE
//  o_done     out  1        one-cycle pulse when a scan completes
// BEHAVIOUR
//  Reset (i_rst_n=0 at edge): o_data=0, o_ch=0, o_valid=0, o_busy=0, o_done=0, ptr=0, state=IDLE.
//   Overrides every other input; reset mid-scan aborts it, no o_done.
//  Slot free: load_ok = !o_valid | i_ready. Handshake: word transfers on o_valid & i_ready.
//  While o_valid & !i_ready: o_data, o_ch held stable; o_valid never drops without a transfer.
//  States: IDLE, SCAN, DRAIN.
//  IDLE, i_mode=0 (direct): if i_en & load_ok, next edge o_data <= ch[i_sel], o_ch <= i_sel, o_valid <= 1.
//   Latency 1 cycle, throughput 1 word/cycle. If !(i_en & load_ok) and transfer occurs, o_valid <= 0.
//   i_sel >= N (non-power-of-2 N): o_data <= 0, o_ch <= i_sel, o_valid <= 1.
//  IDLE, i_mode=1, i_start=1: ptr <= 0, state <= SCAN. No word loads in the start cycle.
//  SCAN: if i_en & load_ok: load ch[ptr], o_ch <= ptr, o_valid <= 1.
//   If ptr == N-1: state <= DRAIN; else ptr <= ptr+1.
//   Otherwise hold ptr and output; i_en=0 pauses scan without loss.
//  DRAIN: on transfer of the last word: o_valid <= 0, o_done <= 1 next cycle, state <= IDLE, ptr <= 0.
//  o_done is high exactly one cycle, in the cycle after the channel N-1 word transfers.
//  i_start in SCAN/DRAIN is ignored; changes of i_mode in SCAN/DRAIN are ignored.
//  Scan order is strictly 0..N-1. Each channel is delivered exactly once; no drop, no duplicate under any i_ready/i_en pattern.
//  i_data is sampled at the load edge only (no snapshot of the full bus at start).
// STRUCTURE
//  Shared header mux_defs_v.vh: state encodings (IDLE/SCAN/DRAIN), mode constants (MODE_DIRECT/MODE_SCAN), clog2 function.
//  Sub-module mux_n_1_w_v: purely combinational N:1, W-bit selector (params W, N).
//   Built as a log2 tree of 2:1 W-bit stages; out-of-range select yields 0.
//  Top level: FSM, ptr counter, output register, handshake. Select mux = i_mode scan ? ptr : i_sel.
// TESTING
//  1 Reset: i_rst_n=0 for 2 cycles with i_en=1, i_start=1 -> o_valid=0, o_data=0, o_busy=0, o_done=0.
//  2 Direct: W=8, N=8, ch5=8'hA5, i_sel=5, i_en=1, i_ready=1 -> next cycle o_data=A5, o_ch=5, o_valid=1.
//  3 Backpressure: after 2, i_ready=0 for 3 cycles, i_sel=2 -> o_data=A5, o_ch=5 held; i_ready=1 -> ch2 loads next cycle.
//  4 Scan: ch k = 8'h10+k, i_mode=1, i_start pulse, i_ready=1 -> o_data 10..17 on 8 consecutive cycles starting 2 cycles after start, o_done=1 one cycle after 17 transfers.
//  5 Scan stress: i_ready random, i_en=0 for 2 cycles mid-scan, i_start re-pulsed while busy -> exactly 10..17 in order, single o_done.
//  6 Reset mid-scan after 3 transfers -> outputs 0, IDLE, no o_done. N=5 direct mode, i_sel=6 -> o_data=0, o_valid=1.

Source files
------------

// File: rtl/mux_n_1_scan_v_pkg.sv
// mux_n_1_scan_v_pkg: shared FSM states, mode constants and select-width helper
package mux_n_1_scan_v_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mux_n_1_scan_v_w.sv
// mux_n_1_scan_v_w: combinational N:1 W-bit selector built as a binary tree, out-of-range select gives 0
module mux_n_1_scan_v_w
   import mux_n_1_scan_v_pkg::*;
#(
   parameter int W = 8,
   parameter int N = 8,
   localparam int SEL_W = sel_w(N)
) (
   input  logic [N*W-1:0]   i_data,
   input  logic [SEL_W-1:0] i_sel,
   output logic [W-1:0]     o_data
);

   localparam int P = 1 << SEL_W;

   logic [W-1:0] node [2*P-1];

   genvar k, n;

   for (k = 0; k < P; k++) begin : g_leaf
      if (k < N) begin : g_ch
         assign node[P-1+k] = i_data[k*W +: W];
      end else begin : g_pad
         assign node[P-1+k] = '0;
      end
   end

   for (n = 0; n < P-1; n++) begin : g_node
      localparam int B = SEL_W - $clog2(n + 2);
      assign node[n] = i_sel[B] ? node[2*n+2] : node[2*n+1];
   end

   assign o_data = node[0];

endmodule

// File: rtl/mux_n_1_scan_v.sv
// mux_n_1_scan_v: registered N:1 mux with valid/ready output, direct and scan modes
module mux_n_1_scan_v
   import mux_n_1_scan_v_pkg::*;
#(
   parameter int W = 8,
   parameter int N = 8,
   localparam int SEL_W = sel_w(N)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_mode,
   input  logic             i_start,
   input  logic [SEL_W-1:0] i_sel,
   input  logic [N*W-1:0]   i_data,
   input  logic             i_ready,
   output logic [W-1:0]     o_data,
   output logic [SEL_W-1:0] o_ch,
   output logic             o_valid,
   output logic             o_busy,
   output logic             o_done
);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d, ch_q, ch_d, sel;
   logic [W-1:0]     data_q, data_d, mux_out;
   logic             valid_q, valid_d, done_q, done_d;
   logic             xfer, load, last;

   mux_n_1_scan_v_w #(.W(W), .N(N)) u_sel (
      .i_data (i_data),
      .i_sel  (sel),
      .o_data (mux_out)
   );

   // next-state: FSM, scan pointer and output slot with handshake
   always_comb begin
      xfer    = valid_q & i_ready;
      load    = i_en & (!valid_q | i_ready);
      last    = ptr_q == SEL_W'(N - 1);
      sel     = (state_q == ST_SCAN) ? ptr_q : i_sel;
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      ch_d    = ch_q;
      valid_d = valid_q & !xfer;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_mode == MODE_SCAN) begin
               if (i_start) begin
                  state_d = ST_SCAN;
                  ptr_d   = '0;
               end
            end else if (load) begin
               data_d  = mux_out;
               ch_d    = sel;
               valid_d = 1'b1;
            end
         end
         ST_SCAN: begin
            if (load) begin
               data_d  = mux_out;
               ch_d    = sel;
               valid_d = 1'b1;
               state_d = last ? ST_DRAIN : ST_SCAN;
               ptr_d   = last ? ptr_q : ptr_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (xfer) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         data_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign o_data  = data_q;
   assign o_ch    = ch_q;
   assign o_valid = valid_q;
   assign o_done  = done_q;
   assign o_busy  = state_q != ST_IDLE;

endmodule

// File: tb/tb_mux_n_1_scan_v.sv
// tb_mux_n_1_scan_v: directed self-checking bench for the scan mux (N=8 and N=5 instances)
module tb_mux_n_1_scan_v;

   logic        clk = 1'b0;
   logic        rst_n, en, mode, start, ready;
   logic [2:0]  sel, ch8;
   logic [63:0] data8;
   logic [7:0]  dout8;
   logic        valid8, busy8, done8;
   logic [2:0]  sel5, ch5;
   logic [39:0] data5;
   logic [7:0]  dout5;
   logic        valid5, busy5, done5;
   logic [15:0] pat;
   logic [7:0]  pd;
   logic [2:0]  pc;
   logic        pv;
   int          checks = 0;
   int          errors = 0;
   int          idx, nd;

   always #5 clk = ~clk;

   mux_n_1_scan_v #(.W(8), .N(8)) dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_start(start),
      .i_sel(sel), .i_data(data8), .i_ready(ready),
      .o_data(dout8), .o_ch(ch8), .o_valid(valid8), .o_busy(busy8), .o_done(done8)
   );

   mux_n_1_scan_v #(.W(8), .N(5)) dut5 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(1'b0), .i_start(1'b0),
      .i_sel(sel5), .i_data(data5), .i_ready(ready),
      .o_data(dout5), .o_ch(ch5), .o_valid(valid5), .o_busy(busy5), .o_done(done5)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; start = 1'b1; mode = 1'b0; ready = 1'b1; sel = 3'd0; sel5 = 3'd0;
      pat = 16'b0110_1011_0100_1101;
      for (int k = 0; k < 8; k++) data8[k*8 +: 8] = 8'(k * 17);
      data8[5*8 +: 8] = 8'hA5;
      for (int k = 0; k < 5; k++) data5[k*8 +: 8] = 8'(8'h50 + k);
      step();
      step();
      chk("rst_valid", 32'(valid8), 0);
      chk("rst_data", 32'(dout8), 0);
      chk("rst_ch", 32'(ch8), 0);
      chk("rst_busy", 32'(busy8), 0);
      chk("rst_done", 32'(done8), 0);
      chk("rst_valid5", 32'(valid5), 0);
      rst_n = 1'b1; start = 1'b0; sel = 3'd5;
      step();
      chk("dir_data", 32'(dout8), 'hA5);
      chk("dir_ch", 32'(ch8), 5);
      chk("dir_valid", 32'(valid8), 1);
      ready = 1'b0; sel = 3'd2;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_data", 32'(dout8), 'hA5);
         chk("bp_ch", 32'(ch8), 5);
         chk("bp_valid", 32'(valid8), 1);
      end
      ready = 1'b1;
      step();
      chk("bp_rel_data", 32'(dout8), 'h22);
      chk("bp_rel_ch", 32'(ch8), 2);
      en = 1'b0;
      step();
      chk("en_off_valid", 32'(valid8), 0);
      en = 1'b1;
      for (int k = 0; k < 8; k++) data8[k*8 +: 8] = 8'(8'h10 + k);
      mode = 1'b1; start = 1'b1;
      step();
      chk("start_busy", 32'(busy8), 1);
      chk("start_valid", 32'(valid8), 0);
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("scan_data", 32'(dout8), 32'(16 + k));
         chk("scan_ch", 32'(ch8), 32'(k));
         chk("scan_valid", 32'(valid8), 1);
         chk("scan_nodone", 32'(done8), 0);
      end
      step();
      chk("scan_done", 32'(done8), 1);
      chk("scan_end_valid", 32'(valid8), 0);
      chk("scan_end_busy", 32'(busy8), 0);
      step();
      chk("done_pulse", 32'(done8), 0);
      idx = 0; nd = 0;
      for (int c = 0; c < 60; c++) begin
         ready = (c >= 40) ? 1'b1 : pat[c % 16];
         en    = !(c == 4 || c == 5);
         start = (c == 0 || c == 9);
         mode  = (c == 8) ? 1'b0 : 1'b1;
         pv = valid8; pd = dout8; pc = ch8;
         step();
         if (pv && ready) begin
            chk("stress_word", 32'(pd), 32'(16 + idx));
            chk("stress_ch", 32'(pc), 32'(idx));
            idx++;
         end else if (pv) begin
            chk("stress_hold_data", 32'(dout8), 32'(pd));
            chk("stress_hold_valid", 32'(valid8), 1);
         end
         if (done8) nd++;
      end
      start = 1'b0; mode = 1'b1;
      chk("stress_count", 32'(idx), 8);
      chk("stress_done_count", 32'(nd), 1);
      chk("stress_idle", 32'(busy8), 0);
      ready = 1'b1; en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("mid_data", 32'(dout8), 'h13);
      rst_n = 1'b0;
      step();
      chk("abort_valid", 32'(valid8), 0);
      chk("abort_data", 32'(dout8), 0);
      chk("abort_ch", 32'(ch8), 0);
      chk("abort_busy", 32'(busy8), 0);
      chk("abort_done", 32'(done8), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_abort_done", 32'(done8), 0);
         chk("post_abort_busy", 32'(busy8), 0);
         chk("post_abort_valid", 32'(valid8), 0);
      end
      sel5 = 3'd4;
      step();
      chk("n5_ch4_data", 32'(dout5), 'h54);
      chk("n5_ch4_ch", 32'(ch5), 4);
      sel5 = 3'd6;
      step();
      chk("n5_oor_data", 32'(dout5), 0);
      chk("n5_oor_ch", 32'(ch5), 6);
      chk("n5_oor_valid", 32'(valid5), 1);
      sel5 = 3'd7;
      step();
      chk("n5_oor7_data", 32'(dout5), 0);
      chk("n5_busy", 32'(busy5), 0);
      chk("n5_done", 32'(done5), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
